// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Default geometry plus the architectural register numbers the harness relies on.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_NRD    = 2;
    localparam int ZERO_REG   = 0;
    localparam int V0_REG     = 2;
endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of read, write-back, reservation and debug signals for regfile_sb.
// The slave modport is the register file; the master is the pipeline or harness.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = DEF_NRD
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wen0;
    logic [AW-1:0]         waddr0;
    logic [DATA_W-1:0]     wdata0;
    logic                  wen1;
    logic [AW-1:0]         waddr1;
    logic [DATA_W-1:0]     wdata1;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic [AW-1:0]         dbg_addr;
    logic [DATA_W-1:0]     dbg_data;
    logic [NREGS-1:0]      pend_vec;
    logic                  err;

    modport slave (
        input  rd_addr, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
               rsv_en, rsv_addr, dbg_addr,
        output rd_data, rd_busy, dbg_data, pend_vec, err
    );

    modport master (
        output rd_addr, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
               rsv_en, rsv_addr, dbg_addr,
        input  rd_data, rd_busy, dbg_data, pend_vec, err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard for long-latency results.
// Flags WAW reservations and ALU writes to pending registers as hazards.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen0,
    input  logic [AW-1:0]    waddr0,
    input  logic             wen1,
    input  logic [AW-1:0]    waddr1,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [NREGS-1:0] pend_vec,
    output logic             hazard
);
    localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic             clr, set, waw, raw_alu;

    assign clr = wen1 && waddr1 != R0;
    assign set = rsv_en && rsv_addr != R0;

    // A reservation racing the completing write of the same register is a
    // legal re-issue, not a WAW.
    assign waw     = set && pend[rsv_addr] && !(clr && waddr1 == rsv_addr);
    assign raw_alu = wen0 && waddr0 != R0 && pend[waddr0];
    assign hazard  = waw || raw_alu;

    always_comb begin
        pend_nxt = pend;
        if (clr) pend_nxt[waddr1] = 1'b0;
        if (set) pend_nxt[rsv_addr] = 1'b1;
        pend_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    assign pend_vec = pend;
endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD read ports, ALU and long-latency write-back ports,
// optional write-through bypass, pending scoreboard and sticky hazard flag.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = DEF_NRD,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             pend;
    logic                         w0, w1, hz_dual, hz_sb, err;

    assign w0      = bus.wen0 && bus.waddr0 != R0;
    assign w1      = bus.wen1 && bus.waddr1 != R0;
    assign hz_dual = w0 && w1 && bus.waddr0 == bus.waddr1;

    // wb0 is the younger instruction, so its write lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            if (w1) regs[bus.waddr1] <= bus.wdata1;
            if (w0) regs[bus.waddr0] <= bus.wdata0;
        end
    end

    regfile_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wen0     (bus.wen0),
        .waddr0   (bus.waddr0),
        .wen1     (bus.wen1),
        .waddr1   (bus.waddr1),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .pend_vec (pend),
        .hazard   (hz_sb)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0, hit1;
        assign a    = bus.rd_addr[i*AW +: AW];
        assign hit0 = (BYPASS != 0) && w0 && bus.waddr0 == a;
        assign hit1 = (BYPASS != 0) && w1 && bus.waddr1 == a;
        assign bus.rd_data[i*DATA_W +: DATA_W] =
            hit0 ? bus.wdata0 :
            hit1 ? bus.wdata1 :
            (a == R0) ? '0 : regs[a];
        // Forwarded long-latency data satisfies the consumer this cycle.
        assign bus.rd_busy[i] = pend[a] && !hit1;
    end

    always_ff @(posedge clk) begin
        if (rst)                  err <= 1'b0;
        else if (hz_dual || hz_sb) err <= 1'b1;
    end

    assign bus.dbg_data = (bus.dbg_addr == R0) ? '0 : regs[bus.dbg_addr];
    assign bus.pend_vec = pend;
    assign bus.err      = err;
endmodule

// File: tb/tb_regfile_sb.sv
// Drives a BYPASS=1 and a BYPASS=0 register file with identical stimulus and
// compares both against an array-based reference model every cycle.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 32, NR = 32, ND = 2, AW = 5;

    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    logic [ND*AW-1:0] rd_addr;
    logic             wen0, wen1, rsv_en;
    logic [AW-1:0]    waddr0, waddr1, rsv_addr, dbg_addr;
    logic [DW-1:0]    wdata0, wdata1;

    regfile_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(ND)) b1 ();
    regfile_sb_if #(.DATA_W(DW), .NREGS(NR), .NRD(ND)) b0 ();

    assign b1.rd_addr = rd_addr;   assign b0.rd_addr = rd_addr;
    assign b1.wen0 = wen0;         assign b0.wen0 = wen0;
    assign b1.waddr0 = waddr0;     assign b0.waddr0 = waddr0;
    assign b1.wdata0 = wdata0;     assign b0.wdata0 = wdata0;
    assign b1.wen1 = wen1;         assign b0.wen1 = wen1;
    assign b1.waddr1 = waddr1;     assign b0.waddr1 = waddr1;
    assign b1.wdata1 = wdata1;     assign b0.wdata1 = wdata1;
    assign b1.rsv_en = rsv_en;     assign b0.rsv_en = rsv_en;
    assign b1.rsv_addr = rsv_addr; assign b0.rsv_addr = rsv_addr;
    assign b1.dbg_addr = dbg_addr; assign b0.dbg_addr = dbg_addr;

    regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(ND), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(ND), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    // Reference model: architectural state as plain arrays.
    logic [DW-1:0] mem [NR];
    bit            pnd [NR];
    bit            merr;
    bit            chk_en;
    int            checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input int byp, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp != 0 && wen0 && waddr0 == a) return wdata0;
        if (byp != 0 && wen1 && waddr1 == a) return wdata1;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input int byp, input logic [AW-1:0] a);
        return pnd[a] && !(byp != 0 && wen1 && waddr1 == a);
    endfunction

    function automatic logic [NR-1:0] exp_pv();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = pnd[r];
        return v;
    endfunction

    task automatic check_dut(input int byp, input logic [ND*DW-1:0] rdd, input logic [ND-1:0] bsy,
                             input logic [DW-1:0] dbg, input logic [NR-1:0] pv, input logic e);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("b%0d_rd%0d_a%0d", byp, i, rd_addr[i*AW +: AW]),
                64'(rdd[i*DW +: DW]), 64'(exp_rd(byp, rd_addr[i*AW +: AW])));
            chk($sformatf("b%0d_busy%0d", byp, i), 64'(bsy[i]), 64'(exp_busy(byp, rd_addr[i*AW +: AW])));
        end
        chk($sformatf("b%0d_dbg_a%0d", byp, dbg_addr), 64'(dbg), 64'((dbg_addr == 0) ? '0 : mem[dbg_addr]));
        chk($sformatf("b%0d_pend", byp), 64'(pv), 64'(exp_pv()));
        chk($sformatf("b%0d_err", byp), 64'(e), 64'(merr));
    endtask

    task automatic model_edge();
        bit e;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin mem[r] = '0; pnd[r] = 0; end
            merr = 0;
        end else begin
            e = 0;
            if (wen0 && wen1 && waddr0 == waddr1 && waddr0 != 0) e = 1;
            if (rsv_en && rsv_addr != 0 && pnd[rsv_addr] && !(wen1 && waddr1 == rsv_addr)) e = 1;
            if (wen0 && waddr0 != 0 && pnd[waddr0]) e = 1;
            if (wen1 && waddr1 != 0) mem[waddr1] = wdata1;
            if (wen0 && waddr0 != 0) mem[waddr0] = wdata0;
            if (wen1) pnd[waddr1] = 0;
            if (rsv_en && rsv_addr != 0) pnd[rsv_addr] = 1;
            merr = merr | e;
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic sample();
        #4;
        if (chk_en) begin
            check_dut(1, b1.rd_data, b1.rd_busy, b1.dbg_data, b1.pend_vec, b1.err);
            check_dut(0, b0.rd_data, b0.rd_busy, b0.dbg_data, b0.pend_vec, b0.err);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        sample();
        edge_();
    endtask

    task automatic idle();
        rst = 0; wen0 = 0; wen1 = 0; rsv_en = 0;
    endtask

    initial begin
        chk_en = 0;
        rst = 1; wen0 = 0; wen1 = 0; rsv_en = 0;
        waddr0 = '0; waddr1 = '0; rsv_addr = '0; dbg_addr = AW'(V0_REG);
        wdata0 = '0; wdata1 = '0; rd_addr = '0;
        cyc();
        chk_en = 1;

        // Post-reset state, then ALU write to r5 read back next cycle.
        idle(); rd_addr = {AW'(7), AW'(5)};
        sample();
        chk("rst_rd0", 64'(b1.rd_data[31:0]), 64'h0);
        chk("rst_err", 64'(b1.err), 64'h0);
        edge_();
        wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        cyc();
        idle();
        sample();
        chk("r5_rd", 64'(b1.rd_data[31:0]), 64'hDEADBEEF);
        chk("r5_busy", 64'(b1.rd_busy[0]), 64'h0);
        edge_();

        // Same-cycle long-latency write to r7, forwarded only with bypass.
        wen1 = 1; waddr1 = 7; wdata1 = 32'h12345678;
        sample();
        chk("byp1_r7", 64'(b1.rd_data[63:32]), 64'h12345678);
        chk("byp0_r7", 64'(b0.rd_data[63:32]), 64'h0);
        edge_();

        // Reserve r9, hold three cycles, then complete it on wb1.
        idle(); rsv_en = 1; rsv_addr = 9; rd_addr = {AW'(3), AW'(9)};
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("r9_busy", 64'(b1.rd_busy[0]), 64'h1);
            chk("r9_pend", 64'(b1.pend_vec[9]), 64'h1);
            edge_();
        end
        wen1 = 1; waddr1 = 9; wdata1 = 32'hA5;
        sample();
        chk("r9_busy_byp1", 64'(b1.rd_busy[0]), 64'h0);
        chk("r9_busy_byp0", 64'(b0.rd_busy[0]), 64'h1);
        edge_();
        idle();
        sample();
        chk("r9_pend_clr", 64'(b1.pend_vec[9]), 64'h0);
        edge_();

        // Register 0 ignores writes and reservations.
        wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF;
        wen1 = 1; waddr1 = 0; wdata1 = 32'hFFFF;
        rsv_en = 1; rsv_addr = 0; rd_addr = '0; dbg_addr = 0;
        cyc();
        idle();
        sample();
        chk("r0_rd", 64'(b1.rd_data[31:0]), 64'h0);
        chk("r0_pend", 64'(b1.pend_vec[0]), 64'h0);
        chk("r0_err", 64'(b1.err), 64'h0);
        edge_();

        // Dual write collision, repeated reservation, then reset clears everything.
        wen0 = 1; waddr0 = 3; wdata0 = 1; wen1 = 1; waddr1 = 3; wdata1 = 2;
        cyc();
        idle(); rd_addr = {AW'(5), AW'(3)};
        sample();
        chk("r3_wb0_wins", 64'(b1.rd_data[31:0]), 64'h1);
        chk("dual_err", 64'(b1.err), 64'h1);
        edge_();
        rsv_en = 1; rsv_addr = 4;
        cyc(); cyc();
        idle();
        sample();
        chk("waw_err", 64'(b0.err), 64'h1);
        edge_();
        wen0 = 1; waddr0 = 2; wdata0 = 32'hCAFE; dbg_addr = AW'(V0_REG);
        cyc();
        idle(); rst = 1;
        cyc();
        idle();
        for (int a = 0; a < NR; a += 2) begin
            rd_addr = {AW'(a + 1), AW'(a)};
            cyc();
        end

        // Reservation and write presented together with reset are discarded.
        rst = 1; rsv_en = 1; rsv_addr = 6; wen0 = 1; waddr0 = 6; wdata0 = 32'h77;
        cyc();
        idle(); rd_addr = {AW'(0), AW'(6)};
        sample();
        chk("rst_pend", 64'(b1.pend_vec), 64'h0);
        chk("rst_r6", 64'(b1.rd_data[31:0]), 64'h0);
        edge_();

        // Randomized traffic on a narrow address window to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 79) == 0);
            wen0     = $urandom_range(0, 1) == 1;
            wen1     = $urandom_range(0, 2) == 0;
            rsv_en   = $urandom_range(0, 3) == 0;
            waddr0   = AW'($urandom_range(0, 7));
            waddr1   = AW'($urandom_range(0, 7));
            rsv_addr = AW'($urandom_range(0, 7));
            wdata0   = $urandom;
            wdata1   = $urandom;
            rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            dbg_addr = AW'($urandom_range(0, NR - 1));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write MIPS register file.
- Provides NRD combinational read ports and two write-back ports: wb0 for the ALU path, wb1 for the long-latency load and mul/div path.
- Adds optional write-through bypass, a per-register pending scoreboard for long-latency destinations, a sticky hazard-error flag and a debug read tap.
- Sits between decode/issue (reads, reservations) and the write-back stages of the pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), address width (derived; not overridden).
- NRD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- rd_busy  out  NRD  port i source register is pending and not satisfied this cycle.
- wen0  in  1  ALU write enable.
- waddr0  in  AW  ALU write address.
- wdata0  in  DATA_W  ALU write data.
- wen1  in  1  long-latency write enable; also clears pending for waddr1.
- waddr1  in  AW  long-latency write address.
- wdata1  in  DATA_W  long-latency write data.
- rsv_en  in  1  reserve a destination (marks it pending).
- rsv_addr  in  AW  register to reserve.
- dbg_addr  in  AW  debug tap address.
- dbg_data  out  DATA_W  stored contents at dbg_addr; never bypassed.
- pend_vec  out  NREGS  pending bit per register.
- err  out  1  sticky hazard flag.

Behaviour:
- Reset:
  - Synchronous; when rst=1 at an edge: all registers 0, all pending bits 0, err 0.
  - rst overrides any write, reservation or clear presented in the same cycle.
  - No initial-block dependence; contents are undefined until the first reset.
  - After reset: rd_data 0, rd_busy 0, pend_vec 0, dbg_data 0, err 0.
- Register 0:
  - Always reads 0 on all ports, including the bypass path and dbg_data.
  - Writes to it are dropped.
  - It is never pending; rsv_addr=0 is ignored.
  - It never triggers err.
- Writes:
  - Take effect at the edge; the new value is visible in storage the next cycle.
  - wen0 and wen1 to different nonzero addresses: both are written.
  - Same nonzero address in the same cycle: wdata0 is written (ALU is the younger instruction) and err is set.
- Reads:
  - Combinational, zero latency.
  - With BYPASS=1 and a live write to a nonzero rd_addr this cycle, rd_data returns the write data.
  - When both write ports hit the same read address, wdata0 is forwarded.
  - With BYPASS=0, rd_data returns stored contents only.
- Scoreboard, next state per register r≠0:
  - Set if rsv_en and rsv_addr==r.
  - Else clear if wen1 and waddr1==r.
  - Else hold.
  - Reservation beats a same-cycle clear of the same register.
  - wen0 never changes pending bits.
- rd_busy[i]:
  - Equals pend[rd_addr_i].
  - Forced to 0 when BYPASS=1 and wen1 writes rd_addr_i this cycle, since the data is forwarded.
  - A same-cycle reservation is not visible until the next cycle.
- err is sticky until reset. It sets at the edge when any of the following occurs:
  - a) wen0 and wen1 hit the same nonzero address;
  - b) rsv_en targets a pending register that wen1 is not clearing in the same cycle (WAW);
  - c) wen0 writes a pending register.
  - In every error case the write or reservation still takes effect as described above.
- No internal multi-cycle sequencing. All latency is 1 edge for state and 0 for reads.

Decomposition:
- Shared package regfile_pkg:
  - Default DATA_W/NREGS/NRD constants.
  - ZERO_REG = 0.
  - V0_REG = 2, used by the harness through dbg_addr.
- Sub-module regfile_scoreboard:
  - Holds the pending vector, the set/clear priority and error cases b) and c).
  - Exports pend_vec.
  - The top keeps storage, bypass muxing and error case a).

Test Plan:
- Reset, then write 0xDEADBEEF to r5 via wb0, then read r5 on port 0 next cycle -> 0xDEADBEEF; rd_busy=0; err=0.
- BYPASS=1: same cycle wen1 r7=0x12345678 and rd_addr1=7 -> rd_data1=0x12345678 combinationally. BYPASS=0 -> old value 0.
- rsv r9, then 3 idle cycles -> rd_busy=1 and pend_vec[9]=1 throughout. Then wen1 r9=0xA5 -> that cycle rd_busy=0 (bypass); next cycle pend_vec[9]=0.
- Write 0xFFFF to r0 via both ports and rsv r0 -> r0 reads 0, pend_vec[0]=0, err stays 0.
- wen0 r3=1 and wen1 r3=2 in the same cycle -> r3=1 and err=1. Then rsv r4 twice without a clear -> err remains 1. Then rst -> err=0, all registers read 0.
- rsv r6 concurrent with rst=1 -> pend_vec=0 after the edge. A write presented in the same cycle as rst is also discarded.
